fifo_stream_reader: RTL

- Downstream consumer stage for the team's synchronous FIFO.
- Converts the FIFO read-side interface into a valid/ready stream: read strobe, registered data one cycle later, and empty flag.
- Sustains 1 word/cycle when the sink is always ready.
- Never loses or duplicates a word under arbitrary back-pressure, using a 2-entry output buffer plus in-flight read tracking.

---
 rtl/fifo_stream_pkg.sv | 15 +
 rtl/stream_skid_buf.sv | 50 +++++
 rtl/fifo_stream_reader.sv | 87 ++++++++
 3 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared constants and types for the FIFO-to-stream reader.
// The optional STREAM_STATS_EN build uses STATS_W and sat_inc for its counters.
package fifo_stream_pkg;

    localparam int OUT_BUF_DEPTH = 2;
    localparam int STATS_W       = 32;

    typedef logic [1:0] occ_t;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry register FIFO that holds words captured from the upstream FIFO.
// head_data_o always shows the oldest entry; occupancy is reported on buf_cnt_o.
module stream_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [1:0]            buf_cnt_o,
    output logic [DATA_WIDTH-1:0] head_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [OUT_BUF_DEPTH];
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    occ_t                  cnt_q, cnt_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        head_d = head_q;
        tail_d = tail_q;
        if (push_i) tail_d = ~tail_q;
        if (pop_i)  head_d = ~head_q;
        cnt_d = cnt_q + occ_t'(push_i) - occ_t'(pop_i);
    end

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rstn) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
            cnt_q  <= '0;
            // NOTE: the storage is reset too, because its head entry is visible on m_data during reset.
            for (int i = 0; i < OUT_BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            if (push_i) mem_q[tail_q] <= push_data_i;
        end
    end

    assign buf_cnt_o   = cnt_q;
    assign head_data_o = mem_q[head_q];

endmodule

// File: rtl/fifo_stream_reader.sv
// Turns the synchronous FIFO read port into a valid/ready stream at 1 word/cycle.
// Define STREAM_STATS_EN to add the stats_clr/xfer_count/stall_count counters.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef STREAM_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [STATS_W-1:0]    xfer_count,
    output logic [STATS_W-1:0]    stall_count
`endif
);

    logic       inflight_q, inflight_d;
    logic [1:0] buf_cnt;
    logic       pop;
    occ_t       occ, occ_after_pop;

    assign m_valid = (buf_cnt != 2'd0);
    assign pop     = m_valid & m_ready;

    // Words owned by this stage: buffered plus the one whose data lands this cycle.
    assign occ           = buf_cnt + occ_t'(inflight_q);
    assign occ_after_pop = occ - occ_t'(pop);

    // Only issue when the word will have a guaranteed slot; rstn gating keeps reads off during reset.
    assign fifo_rd_en = rstn & ~fifo_empty & (occ_after_pop < occ_t'(OUT_BUF_DEPTH));
    assign inflight_d = fifo_rd_en;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) inflight_q <= 1'b0;
        else       inflight_q <= inflight_d;
    end

    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (inflight_q),
        .push_data_i (fifo_dout),
        .pop_i       (pop),
        .buf_cnt_o   (buf_cnt),
        .head_data_o (m_data)
    );

`ifdef STREAM_STATS_EN
    logic [STATS_W-1:0] xfer_q, xfer_d;
    logic [STATS_W-1:0] stall_q, stall_d;

    always_comb begin
        xfer_d  = xfer_q;
        stall_d = stall_q;
        if (stats_clr) begin
            xfer_d  = '0;
            stall_d = '0;
        end else begin
            if (pop)                 xfer_d  = sat_inc(xfer_q);
            if (m_valid & ~m_ready)  stall_d = sat_inc(stall_q);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            xfer_q  <= '0;
            stall_q <= '0;
        end else begin
            xfer_q  <= xfer_d;
            stall_q <= stall_d;
        end
    end

    assign xfer_count  = xfer_q;
    assign stall_count = stall_q;
`endif

endmodule
